// File: rtl/ahb_resp_mux_n.sv
// Routes read data and responses from NUM_SLV slaves to the master, with a built-in
// default slave that errors unmapped transfers and a watchdog that errors hung slaves.
module ahb_resp_mux_n #(
    parameter int NUM_SLV     = 3,
    parameter int SW          = 2,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [SW-1:0]         SEL,
    input  logic [1:0]            HTRANS,
    input  logic [NUM_SLV*DW-1:0] HRDATA_S,
    input  logic [NUM_SLV*2-1:0]  HRESP_S,
    input  logic [NUM_SLV-1:0]    HREADYOUT_S,
    output logic [DW-1:0]         HRDATA,
    output logic [1:0]            HRESP,
    output logic                  HREADY,
    output logic [SW-1:0]         DP_SEL,
    output logic                  TIMEOUT
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_PASS,
        ST_ERR2,
        ST_TOUT2
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   dp_sel;
    logic            dp_act;
    logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
    logic [SW-1:0]   sel_eff;
    logic            slv_hit;
    logic [DW-1:0]   slv_rdata;
    logic [1:0]      slv_resp;
    logic            slv_ready;
    logic            wd_fire;
    logic            htrans_unused;

    // Only HTRANS[1] distinguishes a real transfer from IDLE/BUSY.
    assign htrans_unused = HTRANS[0];

    // Out-of-range selects are folded onto the default slave at capture time.
    assign sel_eff = (SEL > SW'(NUM_SLV)) ? '0 : SEL;
    assign DP_SEL  = dp_sel;

    always_comb begin
        slv_hit   = 1'b0;
        slv_rdata = '0;
        slv_resp  = RESP_OKAY;
        slv_ready = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dp_sel == SW'(i + 1)) begin
                slv_hit   = 1'b1;
                slv_rdata = HRDATA_S[i*DW +: DW];
                slv_resp  = HRESP_S[i*2 +: 2];
                slv_ready = HREADYOUT_S[i];
            end
        end
    end

    // A slave that becomes ready on the limit cycle wins over the watchdog.
    always_comb begin
        wd_fire = 1'b0;
        if ((TIMEOUT_CYC > 0) && (state == ST_PASS) && slv_hit && dp_act &&
            !slv_ready && (wait_cnt == WD_LAST)) begin
            wd_fire = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        HRDATA       = '0;
        HRESP        = RESP_OKAY;
        HREADY       = 1'b1;
        TIMEOUT      = 1'b0;
        case (state)
            ST_PASS: begin
                if (slv_hit) begin
                    if (wd_fire) begin
                        HREADY    = 1'b0;
                        HRESP     = RESP_ERROR;
                        TIMEOUT   = 1'b1;
                        state_nxt = ST_TOUT2;
                    end else begin
                        HRDATA = slv_rdata;
                        HRESP  = slv_resp;
                        HREADY = slv_ready;
                        if (dp_act && !slv_ready && (wait_cnt != '1)) begin
                            wait_cnt_nxt = wait_cnt + CW'(1);
                        end else if (dp_act && !slv_ready) begin
                            wait_cnt_nxt = wait_cnt;
                        end
                    end
                end else if (dp_act) begin
                    HREADY    = 1'b0;
                    HRESP     = RESP_ERROR;
                    state_nxt = ST_ERR2;
                end
            end
            ST_ERR2, ST_TOUT2: begin
                HRESP     = RESP_ERROR;
                state_nxt = ST_PASS;
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_PASS;
            dp_sel   <= '0;
            dp_act   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (HREADY) begin
                dp_sel <= sel_eff;
                dp_act <= HTRANS[1];
            end
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Randomized plus directed bench for ahb_resp_mux_n, checked each cycle against a
// transfer-level reference model of the data phase.
module tb_ahb_resp_mux_n;

    localparam int N  = 3;
    localparam int SW = 3;
    localparam int DW = 32;
    localparam int TC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [SW-1:0]     sel;
    logic [1:0]        htrans;
    logic [N*DW-1:0]   hrdata_s;
    logic [N*2-1:0]    hresp_s;
    logic [N-1:0]      hreadyout_s;
    logic [DW-1:0]     hrdata;
    logic [1:0]        hresp;
    logic              hready;
    logic [SW-1:0]     dp_sel;
    logic              timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int tout_cnt = 0;

    // Reference model: which transfer owns the data phase and how far along it is.
    int m_slv;
    bit m_act;
    bit m_err2;
    int m_waits;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    ahb_resp_mux_n #(.NUM_SLV(N), .SW(SW), .DW(DW), .TIMEOUT_CYC(TC)) u_dut (
        .CLK(clk), .RST(rst), .SEL(sel), .HTRANS(htrans),
        .HRDATA_S(hrdata_s), .HRESP_S(hresp_s), .HREADYOUT_S(hreadyout_s),
        .HRDATA(hrdata), .HRESP(hresp), .HREADY(hready), .DP_SEL(dp_sel), .TIMEOUT(timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are already applied; check this cycle's outputs, then advance the model.
    task automatic step();
        logic        e_rdy, e_to, chk_dat, r, fire, nxt_err2;
        logic [1:0]  e_resp;
        logic [DW-1:0] e_dat;
        @(negedge clk);
        e_rdy = 1'b1; e_resp = 2'b00; e_dat = '0; e_to = 1'b0;
        chk_dat = 1'b1; r = 1'b1; fire = 1'b0;
        if (m_err2) begin
            e_resp = 2'b01;
        end else if (m_slv == 0) begin
            if (m_act) begin
                e_rdy  = 1'b0;
                e_resp = 2'b01;
            end
        end else begin
            r = hreadyout_s[m_slv-1];
            if (TC > 0 && m_act && !r && m_waits == TC - 1) begin
                fire = 1'b1; e_rdy = 1'b0; e_resp = 2'b01; e_to = 1'b1; chk_dat = 1'b0;
            end else begin
                e_rdy  = r;
                e_resp = hresp_s[2*(m_slv-1) +: 2];
                e_dat  = hrdata_s[DW*(m_slv-1) +: DW];
            end
        end
        if (timeout === 1'b1) tout_cnt++;
        if (!rst && m_valid) begin
            check("hready",  64'(hready),  64'(e_rdy));
            check("hresp",   64'(hresp),   64'(e_resp));
            if (chk_dat) check("hrdata", 64'(hrdata), 64'(e_dat));
            check("dp_sel",  64'(dp_sel),  64'(m_slv));
            check("timeout", 64'(timeout), 64'(e_to));
        end
        if (rst) begin
            m_slv = 0; m_act = 1'b0; m_err2 = 1'b0; m_waits = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            nxt_err2 = !m_err2 && !e_rdy && (m_slv == 0 || fire);
            if (!m_err2 && m_slv != 0 && m_act && !r && !fire) m_waits++;
            else m_waits = 0;
            if (e_rdy) begin
                m_slv = (int'(sel) > N) ? 0 : int'(sel);
                m_act = htrans[1];
            end
            m_err2 = nxt_err2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [1:0] t, input logic [N-1:0] rdy);
        sel = SW'(s);
        htrans = t;
        hreadyout_s = rdy;
        hresp_s = '0;
        for (int i = 0; i < N; i++) hrdata_s[DW*i +: DW] = 32'hA5A5_0000 | 32'(i + 1);
    endtask

    task automatic rand_inputs(input int rdy_pct);
        sel    = SW'($urandom_range(0, 7));
        htrans = 2'($urandom);
        for (int i = 0; i < N; i++) begin
            hrdata_s[DW*i +: DW] = $urandom;
            hresp_s[2*i +: 2]    = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            hreadyout_s[i]       = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        int t0;
        int rdy_pct;
        rst = 1'b1;
        rand_inputs(50);
        step();
        rand_inputs(50);
        step();
        rst = 1'b0;
        drive(0, 2'b00, '1);
        step();

        // Back-to-back routing to every slave.
        for (int n = 1; n <= N; n++) begin
            drive(n, 2'b10, '1);
            step();
        end
        drive(0, 2'b00, '1);
        step();

        // Wait states on slave 1 with an address-phase SEL change while waiting.
        drive(1, 2'b10, '1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(3, 2'b10, 3'b110);
            step();
        end
        drive(3, 2'b10, '1);
        step();
        drive(0, 2'b00, '1);
        step();
        step();

        // Default slave, mapped and out-of-range.
        drive(0, 2'b10, '1);
        step();
        drive(0, 2'b00, '1);
        step(); step(); step();
        drive(5, 2'b11, '1);
        step();
        drive(0, 2'b00, '1);
        step(); step(); step();

        // Watchdog fires once on a stuck slave 3.
        t0 = tout_cnt;
        drive(3, 2'b10, '1);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(0, 2'b00, 3'b011);
            step();
        end
        check("wd_stuck_pulses", 64'(tout_cnt - t0), 64'd1);

        // Slave ready exactly on the limit cycle: no pulse.
        t0 = tout_cnt;
        drive(3, 2'b10, '1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 2'b00, 3'b011);
            step();
        end
        drive(0, 2'b00, '1);
        step();
        step();
        check("wd_late_ready_pulses", 64'(tout_cnt - t0), 64'd0);

        // Reset during the second error cycle and during a slave wait.
        drive(0, 2'b10, '1);
        step();
        drive(0, 2'b00, '1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        drive(2, 2'b10, '1);
        step();
        drive(0, 2'b00, 3'b101);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 2'b00, 3'b101);
        step();

        // Random traffic with varying slave readiness.
        rdy_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) rdy_pct = $urandom_range(5, 95);
            rand_inputs(rdy_pct);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        check("wd_seen_random", 64'(tout_cnt > 1), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
